// File: rtl/vec3_normalize.sv
// vec3_normalize: unit vector of a signed fixed-point vec3.
// One squared-length step, bit-serial sqrt, three serial divides.
module vec3_normalize #(
  parameter int WORD_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3*WORD_WIDTH-1:0] in_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3*WORD_WIDTH-1:0] out_vec,
  output logic                    out_zero
);

  localparam int W    = WORD_WIDTH;
  localparam int F    = FRAC_BITS;
  localparam int LW   = 2*W+2;
  localparam int RW   = W+1;
  localparam int DW   = W+F;
  localparam int MAXP = (DW > RW) ? DW : RW;
  localparam int CW   = $clog2(MAXP+1);

  typedef enum logic [2:0] {
    IDLE, SQSUM, SQRT, DIV, DONE
  } state_t;

  state_t state, nstate;

  logic [CW-1:0]       cnt;
  logic [1:0]          comp;
  logic [2:0]          sgn;
  logic [2:0][W-1:0]   mag;
  logic [LW-1:0]       l2;
  logic [LW-1:0]       rad;
  logic [RW:0]         srem;
  logic [RW-1:0]       root;
  logic [RW+2:0]       s_try;
  logic [RW+2:0]       s_trial;
  logic                s_ge;
  logic [DW-1:0]       dq;
  logic [RW:0]         drem;
  logic [RW+1:0]       d_try;
  logic [RW+1:0]       d_den;
  logic                d_ge;
  logic [W-1:0]        qmag;
  logic [W-1:0]        qval;
  logic [W-1:0]        nmag;
  logic                csgn;
  logic [W-1:0]        resx;
  logic [W-1:0]        resy;

  function automatic logic [W-1:0] absval(
    input logic [W-1:0] c
  );
    return c[W-1] ? -c : c;
  endfunction

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);

  assign l2 = LW'(mag[0]) * LW'(mag[0])
            + LW'(mag[1]) * LW'(mag[1])
            + LW'(mag[2]) * LW'(mag[2]);

  assign s_try   = {srem, rad[LW-1 -: 2]};
  assign s_trial = {1'b0, root, 2'b01};
  assign s_ge    = (s_try >= s_trial);

  assign d_try = {drem, dq[DW-1]};
  assign d_den = {2'b00, root};
  assign d_ge  = (d_try >= d_den);
  assign qmag  = {dq[W-2:0], d_ge};
  assign qval  = csgn ? -qmag : qmag;

  // component sign and next dividend for the active divide
  always_comb begin
    csgn = sgn[2];
    nmag = mag[2];
    if (comp == 2'd0) begin
      csgn = sgn[0];
      nmag = mag[1];
    end else if (comp == 2'd1) begin
      csgn = sgn[1];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (in_valid && in_ready) nstate = SQSUM;
      SQSUM: nstate = (l2 == '0) ? DONE : SQRT;
      SQRT:  if (cnt == CW'(RW-1)) nstate = DIV;
      DIV:   if (cnt == CW'(DW-1) && comp == 2'd2)
               nstate = DONE;
      DONE:  if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // phase counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      comp <= '0;
    end else if (state != nstate) begin
      cnt  <= '0;
      comp <= '0;
    end else if (state == DIV && cnt == CW'(DW-1)) begin
      cnt  <= '0;
      comp <= comp + 2'd1;
    end else if (state == SQRT || state == DIV) begin
      cnt  <= cnt + CW'(1);
    end
  end

  // datapath: capture, sqrt steps, divide steps, result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sgn      <= '0;
      mag      <= '0;
      rad      <= '0;
      srem     <= '0;
      root     <= '0;
      dq       <= '0;
      drem     <= '0;
      resx     <= '0;
      resy     <= '0;
      out_vec  <= '0;
      out_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sgn[0] <= in_vec[3*W-1];
            sgn[1] <= in_vec[2*W-1];
            sgn[2] <= in_vec[W-1];
            mag[0] <= absval(in_vec[3*W-1 -: W]);
            mag[1] <= absval(in_vec[2*W-1 -: W]);
            mag[2] <= absval(in_vec[W-1:0]);
          end
        end
        SQSUM: begin
          rad  <= l2;
          srem <= '0;
          root <= '0;
          if (l2 == '0) begin
            out_vec  <= '0;
            out_zero <= 1'b1;
          end
        end
        SQRT: begin
          rad  <= {rad[LW-3:0], 2'b00};
          srem <= (RW+1)'(s_ge ? s_try - s_trial : s_try);
          root <= {root[RW-2:0], s_ge};
          if (cnt == CW'(RW-1)) begin
            dq   <= {mag[0], {F{1'b0}}};
            drem <= '0;
          end
        end
        DIV: begin
          dq   <= {dq[DW-2:0], d_ge};
          drem <= (RW+1)'(d_ge ? d_try - d_den : d_try);
          if (cnt == CW'(DW-1)) begin
            drem <= '0;
            if (comp == 2'd0) resx <= qval;
            if (comp == 2'd1) resy <= qval;
            if (comp != 2'd2) begin
              dq <= {nmag, {F{1'b0}}};
            end else begin
              out_vec  <= {resx, resy, qval};
              out_zero <= 1'b0;
            end
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec3_normalize.sv
// tb_vec3_normalize: random and directed vectors checked
// against an arithmetic model of v/|v| in fixed point.
module tb_vec3_normalize;

  localparam int LAT = 1 + 33 + 3*48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_vec;
  logic        out_zero;

  vec3_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] v;
    logic        z;
    longint      lat;
    longint      acc;
  } exp_t;

  exp_t   exp_q[$];
  bit     seen;
  int     npass = 0;
  int     ntot  = 0;
  longint cyc   = 0;
  int     rmode = 2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [95:0] act,
                       input logic [95:0] want);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask

  function automatic logic [96:0] model(input logic [95:0] v);
    longint unsigned m[3];
    bit              neg[3];
    longint unsigned l2, lo, hi, mid, q;
    logic [95:0]     r;
    logic [31:0]     c;
    l2 = 0;
    r  = '0;
    for (int i = 0; i < 3; i++) begin
      c      = v[95-32*i -: 32];
      neg[i] = c[31];
      m[i]   = neg[i] ? (64'h1_0000_0000 - {32'b0, c})
                      : {32'b0, c};
      l2    += m[i] * m[i];
    end
    if (l2 == 0) return {1'b1, 96'b0};
    lo = 0;
    hi = 64'hFFFF_FFFF;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= l2) lo = mid;
      else hi = mid - 1;
    end
    for (int i = 0; i < 3; i++) begin
      q = (m[i] << 16) / lo;
      c = q[31:0];
      if (neg[i]) c = -c;
      r[95-32*i -: 32] = c;
    end
    return {1'b0, r};
  endfunction

  function automatic logic [31:0] rcomp();
    logic [31:0] c;
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return $urandom;
      2: return $urandom_range(0, 32'hFFFF);
      3: begin
        c = $urandom & 32'h003F_FFFF;
        return ($urandom_range(0, 1) != 0) ? -c : c;
      end
      4: return 32'h8000_0000;
      default: return 32'h7FFF_FFFF;
    endcase
  endfunction

  // ready pattern for the consumer side
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // compare outputs against the model on every valid cycle
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "spurious_valid", out_vec, 96'h0);
      end else begin
        check(out_vec == exp_q[0].v, "out_vec",
              out_vec, exp_q[0].v);
        check(out_zero == exp_q[0].z, "out_zero",
              96'(out_zero), 96'(exp_q[0].z));
        if (!seen) begin
          check((cyc - exp_q[0].acc) == exp_q[0].lat,
                "latency", 96'(cyc - exp_q[0].acc),
                96'(exp_q[0].lat));
          seen = 1'b1;
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // caller must be positioned just after a negedge
  task automatic send(input logic [95:0] v);
    int          n;
    logic [96:0] e;
    exp_t        x;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check(1'b0, "in_ready_timeout", 96'(in_ready), 96'(1));
      return;
    end
    in_valid = 1'b1;
    in_vec   = v;
    e        = model(v);
    x.v      = e[95:0];
    x.z      = e[96];
    x.lat    = e[96] ? 1 : LAT;
    x.acc    = cyc + 1;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = {$urandom, $urandom, $urandom};
    @(negedge clk);
    check(!in_ready, "in_ready_drop", 96'(in_ready), 96'(0));
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check(1'b0, "result_timeout", 96'(exp_q.size()), 96'(0));
      exp_q.delete();
      seen = 1'b0;
    end
  endtask

  task automatic pin(input logic [95:0] v,
                     input logic [96:0] want, input string name);
    logic [96:0] got;
    got = model(v);
    check(got == want, name, got[95:0], want[95:0]);
  endtask

  initial begin
    logic [95:0] snap;
    logic [95:0] rv;
    bit          ok;
    int          n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    seen      = 1'b0;

    pin({32'h0001_0000, 32'h0, 32'h0},
        {1'b0, 32'h0001_0000, 32'h0, 32'h0}, "model_unit");
    pin({32'h0003_0000, 32'h0004_0000, 32'h0},
        {1'b0, 32'h0000_9999, 32'h0000_CCCC, 32'h0}, "model_34");
    pin({32'hFFFD_0000, 32'h0, 32'h0004_0000},
        {1'b0, 32'hFFFF_6667, 32'h0, 32'h0000_CCCC}, "model_m3");
    pin({32'h8000_0000, 32'h0, 32'h0},
        {1'b0, 32'hFFFF_0000, 32'h0, 32'h0}, "model_min");
    pin(96'h0, {1'b1, 96'h0}, "model_zero");

    repeat (3) @(posedge clk);
    @(negedge clk);
    check(!in_ready, "rst_in_ready", 96'(in_ready), 96'(0));
    check(!out_valid, "rst_out_valid", 96'(out_valid), 96'(0));
    check(out_vec == '0, "rst_out_vec", out_vec, 96'h0);
    check(!out_zero, "rst_out_zero", 96'(out_zero), 96'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    rmode = 2;
    @(negedge clk);
    send({32'h0001_0000, 32'h0, 32'h0});
    wait_empty();
    send({32'h0003_0000, 32'h0004_0000, 32'h0});
    wait_empty();
    send({32'hFFFD_0000, 32'h0, 32'h0004_0000});
    wait_empty();
    send({32'h8000_0000, 32'h0, 32'h0});
    wait_empty();
    send(96'h0);
    wait_empty();

    rmode = 1;
    send({32'hFFFD_0000, 32'h0, 32'h0004_0000});
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(out_valid, "bp_valid", 96'(out_valid), 96'(1));
    snap = out_vec;
    ok   = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ok &= (out_vec == snap) && !in_ready && out_valid;
    end
    check(ok, "bp_hold", out_vec, snap);
    rmode = 2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check(!out_valid && in_ready, "bp_release",
          96'({out_valid, in_ready}), 96'(2'b01));
    send({32'h0, 32'h0, 32'h0002_0000});
    wait_empty();

    send({32'h0007_0000, 32'hFFF0_0000, 32'h0001_2345});
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      ok &= !out_valid && (out_vec == '0) && !out_zero;
    end
    check(ok, "mid_reset_quiet", out_vec, 96'h0);
    send({32'h0, 32'h0005_0000, 32'h0});
    wait_empty();

    rmode = 0;
    for (int i = 0; i < 40; i++) begin
      rv = {rcomp(), rcomp(), rcomp()};
      if (i % 10 == 9) rv = '0;
      send(rv);
    end
    rmode = 2;
    wait_empty();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
